// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared state type and constants for the MEM stage access unit
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mau_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
    localparam int unsigned CTR_W                  = 8;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - saturating 8-bit wait counter with an expiry flag
module mem_timeout_ctr
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // Expired flags the cycle that would be the LIMIT-th consecutive wait cycle.
    localparam logic [CTR_W-1:0] LAST = CTR_W'(LIMIT - 1);

    logic [CTR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count >= LAST);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: data-memory handshake, stall, branch resolve, MEM/WB register
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        zero_mem,
    input  logic        branch_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] add_sum_mem,
    input  logic [31:0] store_data_mem,
    input  logic [4:0]  rd_mem,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic        mem_to_reg_mem,
    input  logic        reg_write_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_result_wb,
    output logic [4:0]  rd_wb,
    output logic        reg_write_wb,
    output logic        mem_to_reg_wb,
    output logic        misalign_err,
    output logic        timeout_err
);

    mau_state_e  r_state;
    logic [31:0] r_rdata;
    logic        r_suppress;

    logic w_mem_op;
    logic w_aligned;
    logic w_start;
    logic w_misalign;
    logic w_expired;
    logic w_ctr_en;
    logic w_wb_block;

    assign w_mem_op   = mem_read_mem | mem_write_mem;
    assign w_aligned  = (alu_result_mem[1:0] == 2'b00);
    assign w_start    = (r_state == IDLE) & w_mem_op & w_aligned;
    assign w_misalign = (r_state == IDLE) & w_mem_op & ~w_aligned;
    assign w_ctr_en   = (r_state == ACCESS) & ~dmem_ready;
    assign w_wb_block = w_misalign | ((r_state == DONE) & r_suppress);

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_start),
        .i_enable  (w_ctr_en),
        .o_expired (w_expired)
    );

    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE:    stall = w_start;
                ACCESS:  stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    assign pc_src        = ~reset & branch_mem & zero_mem & ~stall;
    assign branch_target = reset ? 32'd0 : add_sum_mem;

    // Request signals are registered so they stay frozen for the whole handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rdata      <= '0;
            r_suppress   <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            misalign_err <= w_misalign;
            timeout_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= ACCESS;
                        r_suppress <= 1'b0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_mem & ~mem_read_mem;
                        dmem_addr  <= alu_result_mem;
                        dmem_wdata <= store_data_mem;
                    end
                end
                ACCESS: begin
                    if (dmem_ready) begin
                        r_state  <= DONE;
                        r_rdata  <= dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end else if (w_expired) begin
                        r_state     <= DONE;
                        r_rdata     <= '0;
                        r_suppress  <= 1'b1;
                        timeout_err <= 1'b1;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_wb  <= '0;
            alu_result_wb <= '0;
            rd_wb         <= '0;
            reg_write_wb  <= 1'b0;
            mem_to_reg_wb <= 1'b0;
        end else if (stall) begin
            reg_write_wb  <= 1'b0;
            mem_to_reg_wb <= 1'b0;
        end else begin
            read_data_wb  <= r_rdata;
            alu_result_wb <= alu_result_mem;
            rd_wb         <= rd_mem;
            reg_write_wb  <= reg_write_mem & ~w_wb_block;
            mem_to_reg_wb <= mem_to_reg_mem;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a 4-cycle timeout
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        zero_mem, branch_mem;
    logic [31:0] alu_result_mem, add_sum_mem, store_data_mem;
    logic [4:0]  rd_mem;
    logic        mem_read_mem, mem_write_mem, mem_to_reg_mem, reg_write_mem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall, pc_src;
    logic [31:0] branch_target, read_data_wb, alu_result_wb;
    logic [4:0]  rd_wb;
    logic        reg_write_wb, mem_to_reg_wb, misalign_err, timeout_err;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .zero_mem       (zero_mem),
        .branch_mem     (branch_mem),
        .alu_result_mem (alu_result_mem),
        .add_sum_mem    (add_sum_mem),
        .store_data_mem (store_data_mem),
        .rd_mem         (rd_mem),
        .mem_read_mem   (mem_read_mem),
        .mem_write_mem  (mem_write_mem),
        .mem_to_reg_mem (mem_to_reg_mem),
        .reg_write_mem  (reg_write_mem),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .read_data_wb   (read_data_wb),
        .alu_result_wb  (alu_result_wb),
        .rd_wb          (rd_wb),
        .reg_write_wb   (reg_write_wb),
        .mem_to_reg_wb  (mem_to_reg_wb),
        .misalign_err   (misalign_err),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        rw;
        logic        m2r;
        logic        chk_rdata;
    } wb_t;

    wb_t sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive_idle();
        zero_mem       = 1'b0;
        branch_mem     = 1'b0;
        alu_result_mem = '0;
        add_sum_mem    = '0;
        store_data_mem = '0;
        rd_mem         = '0;
        mem_read_mem   = 1'b0;
        mem_write_mem  = 1'b0;
        mem_to_reg_mem = 1'b0;
        reg_write_mem  = 1'b0;
        dmem_ready     = 1'b0;
        dmem_rdata     = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"}, 32'(dmem_req), 32'd0);
        check_val({tag, "_we"}, 32'(dmem_we), 32'd0);
        check_val({tag, "_addr"}, dmem_addr, 32'd0);
        check_val({tag, "_wdata"}, dmem_wdata, 32'd0);
        check_val({tag, "_stall"}, 32'(stall), 32'd0);
        check_val({tag, "_pc_src"}, 32'(pc_src), 32'd0);
        check_val({tag, "_btgt"}, branch_target, 32'd0);
        check_val({tag, "_rdata_wb"}, read_data_wb, 32'd0);
        check_val({tag, "_alu_wb"}, alu_result_wb, 32'd0);
        check_val({tag, "_rd_wb"}, 32'(rd_wb), 32'd0);
        check_val({tag, "_rw_wb"}, 32'(reg_write_wb), 32'd0);
        check_val({tag, "_m2r_wb"}, 32'(mem_to_reg_wb), 32'd0);
        check_val({tag, "_mis"}, 32'(misalign_err), 32'd0);
        check_val({tag, "_to"}, 32'(timeout_err), 32'd0);
    endtask

    // Called at posedge+1 with the unit idle; dly = ACCESS cycle in which ready rises, 0 = never.
    task automatic issue(input string tag, input logic rd_en, input logic wr_en,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic br, input logic zr,
                         input logic [31:0] tgt, input int dly, input logic [31:0] rval);
        logic memop, mis, amem, s, done;
        int   acc_exp, stall_exp, i, acc, stalls, mis_p, to_p;
        wb_t  e;
        memop     = rd_en | wr_en;
        mis       = memop & (addr[1:0] != 2'b00);
        amem      = memop & ~mis;
        acc_exp   = amem ? ((dly == 0) ? TO : dly) : 0;
        stall_exp = amem ? acc_exp + 1 : 0;
        e.rd        = rd;
        e.alu       = addr;
        e.rdata     = (dly == 0) ? 32'd0 : rval;
        e.rw        = rw & ~mis & ~(amem & (dly == 0));
        e.m2r       = m2r;
        e.chk_rdata = amem & rd_en;
        sb_q.push_back(e);

        mem_read_mem   = rd_en;
        mem_write_mem  = wr_en;
        alu_result_mem = addr;
        store_data_mem = sdata;
        rd_mem         = rd;
        reg_write_mem  = rw;
        mem_to_reg_mem = m2r;
        branch_mem     = br;
        zero_mem       = zr;
        add_sum_mem    = tgt;
        dmem_ready     = 1'b0;

        i = 0; acc = 0; stalls = 0; mis_p = 0; to_p = 0; done = 1'b0;
        while (!done && i < 50) begin
            @(negedge clk);
            s = stall;
            check_val({tag, "_stall"}, 32'(stall), 32'(i < stall_exp));
            check_val({tag, "_pc_src"}, 32'(pc_src), 32'(br & zr & (i >= stall_exp)));
            check_val({tag, "_btgt"}, branch_target, tgt);
            if (i > 0) check_val({tag, "_bubble_rw"}, 32'(reg_write_wb), 32'd0);
            if (s) stalls++;
            @(posedge clk);
            #1;
            if (misalign_err) mis_p++;
            if (timeout_err) to_p++;
            if (dmem_req) begin
                acc++;
                check_val({tag, "_we"}, 32'(dmem_we), 32'(wr_en & ~rd_en));
                check_val({tag, "_addr"}, dmem_addr, addr);
                check_val({tag, "_wdata"}, dmem_wdata, sdata);
                dmem_ready = (acc == dly);
                dmem_rdata = rval;
            end else begin
                dmem_ready = 1'b0;
            end
            i++;
            if (!s) done = 1'b1;
        end
        dmem_ready = 1'b0;
        check_val({tag, "_finished"}, 32'(done), 32'd1);
        check_val({tag, "_stall_cycles"}, 32'(stalls), 32'(stall_exp));
        check_val({tag, "_req_cycles"}, 32'(acc), 32'(acc_exp));
        check_val({tag, "_misalign_pulses"}, 32'(mis_p), 32'(mis));
        check_val({tag, "_timeout_pulses"}, 32'(to_p), 32'(amem && dly == 0));

        e = sb_q.pop_front();
        check_val({tag, "_rd_wb"}, 32'(rd_wb), 32'(e.rd));
        check_val({tag, "_alu_wb"}, alu_result_wb, e.alu);
        check_val({tag, "_rw_wb"}, 32'(reg_write_wb), 32'(e.rw));
        check_val({tag, "_m2r_wb"}, 32'(mem_to_reg_wb), 32'(e.m2r));
        if (e.chk_rdata) check_val({tag, "_rdata_wb"}, read_data_wb, e.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rv;
        int          kind;
        reset = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        issue("alu_br",    1'b0, 1'b0, 32'h0000_1111, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1, 32'h0);
        issue("load",      1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1, 32'hDEAD_BEEF);
        issue("store",     1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3, 32'h5555_AAAA);
        issue("misalign",  1'b1, 1'b0, 32'h0000_0013, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1, 32'h0);
        issue("timeout",   1'b1, 1'b0, 32'h0000_0030, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 32'h0);
        issue("alu_nobr",  1'b0, 1'b0, 32'h0000_2222, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 1, 32'h0);
        issue("rd_wr_both", 1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_0000, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2, 32'h0BAD_F00D);

        for (int n = 0; n < 6; n++) begin
            kind = int'($urandom_range(0, 2));
            ra   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            rv   = $urandom;
            case (kind)
                0: issue("rnd_alu", 1'b0, 1'b0, rv, 32'h0, 5'(n + 10), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1, 32'h0);
                1: issue("rnd_load", 1'b1, 1'b0, ra, 32'h0, 5'(n + 10), 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,
                         int'($urandom_range(1, 3)), rv);
                default: issue("rnd_store", 1'b0, 1'b1, ra, rv, 5'(n + 10), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                               int'($urandom_range(1, 3)), 32'h0);
            endcase
        end

        // Abandon a load in its second ACCESS cycle.
        mem_read_mem   = 1'b1;
        alu_result_mem = 32'h0000_0050;
        rd_mem         = 5'd7;
        reg_write_mem  = 1'b1;
        mem_to_reg_mem = 1'b1;
        dmem_ready     = 1'b0;
        @(posedge clk); #1;
        check_val("rst_acc1_req", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        check_val("rst_acc2_req", 32'(dmem_req), 32'd1);
        reset       = 1'b1;
        branch_mem  = 1'b1;
        zero_mem    = 1'b1;
        add_sum_mem = 32'h40;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        reset = 1'b0;
        drive_idle();

        issue("post_rst", 1'b1, 1'b0, 32'h0000_0060, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2, 32'h7777_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum ACCESS cycles spent waiting for dmem_ready before abort.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 zero_mem, branch_mem  in  1 each  branch condition and branch flag from the EX/MEM register.
REQ-005 alu_result_mem  in  32  memory address for load/store, or ALU result for non-memory instructions.
REQ-006 add_sum_mem  in  32  branch target.
REQ-007 store_data_mem  in  32  store data.
REQ-008 rd_mem  in  5  destination register.
REQ-009 mem_read_mem, mem_write_mem, mem_to_reg_mem, reg_write_mem  in  1 each  control bits from EX/MEM.
REQ-010 dmem_req, dmem_we  out  1 each  data-memory request and write enable.
REQ-011 dmem_addr, dmem_wdata  out  32 each  data-memory address and write data.
REQ-012 dmem_ready  in  1  memory completion; read data is valid in the same cycle.
REQ-013 dmem_rdata  in  32  memory read data.
REQ-014 stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM when high.
REQ-015 pc_src, branch_target  out  1 / 32  taken-branch select and branch target.
REQ-016 read_data_wb, alu_result_wb  out  32 each  MEM/WB data.
REQ-017 rd_wb  out  5; reg_write_wb, mem_to_reg_wb  out  1 each  MEM/WB destination and controls.
REQ-018 misalign_err, timeout_err  out  1 each  single-cycle error pulses.

Function
REQ-019 A memory op is defined as mem_read_mem | mem_write_mem; mem_read_mem has priority if both bits are set.
REQ-020 The FSM states are IDLE, ACCESS and DONE.
REQ-021 IDLE: on an aligned memory op (alu_result_mem[1:0] == 0), stall = 1 and the next state is ACCESS; otherwise stall = 0 and the FSM stays in IDLE.
REQ-022 ACCESS, driven from registers:
- dmem_req = 1; dmem_we = mem_write_mem.
- dmem_addr = captured address; dmem_wdata = captured store data.
- All four outputs stay stable until dmem_ready is sampled high.
- stall = 1.
REQ-023 ACCESS with dmem_ready high: capture dmem_rdata, then go to DONE.
REQ-024 ACCESS with a timeout: after TIMEOUT_CYCLES consecutive cycles with dmem_ready low:
- dmem_req drops;
- timeout_err pulses for one cycle;
- the FSM goes to DONE with captured data = 0 and the write-back is suppressed.
REQ-025 DONE: stall = 0 for exactly one cycle; the next state is IDLE.
REQ-026 Outside ACCESS, dmem_req = 0.
REQ-027 Minimum memory-op latency is 2 stall cycles, reached when ready arrives in the first ACCESS cycle.
REQ-028 The MEM/WB outputs register on every edge while stall = 0:
- read_data_wb = captured data;
- alu_result_wb = alu_result_mem;
- rd_wb = rd_mem;
- mem_to_reg_wb = mem_to_reg_mem;
- reg_write_wb = reg_write_mem, gated by the error suppression rules.
REQ-029 While stall = 1, MEM/WB loads a bubble: reg_write_wb = 0 and mem_to_reg_wb = 0; the data fields hold their values.
REQ-030 A misaligned memory op (alu_result_mem[1:0] != 0) issues no access and does not stall.
- misalign_err pulses for one cycle.
- MEM/WB loads with reg_write_wb = 0.
REQ-031 Branch resolution is combinational:
- pc_src = branch_mem & zero_mem & ~stall;
- branch_target = add_sum_mem.
REQ-032 A non-memory instruction passes to MEM/WB with exactly 1-cycle latency and no stall.
REQ-033 The DONE cycle is the only cycle in which a memory op's MEM/WB write occurs, so an op is never re-issued.
REQ-034 The timeout counter clears on every entry to ACCESS; it is 8 bits wide and saturates.

Reset
REQ-035 Reset returns the FSM to IDLE and clears the timeout counter and the captured data.
REQ-036 Reset clears every registered output to 0, including all MEM/WB fields, dmem_req and both error pulses.
REQ-037 Reset asserted during ACCESS drops dmem_req on the next edge; the memory shall tolerate an abandoned request.
REQ-038 Outputs are driven by combinational decode (stall, pc_src, branch_target) are held at 0 while reset is high.

Structure
REQ-039 The shared package holds the state enum (IDLE, ACCESS, DONE) and the TIMEOUT_CYCLES default constant.
REQ-040 One sub-module, mem_timeout_ctr, holds the clear/enable/saturating 8-bit counter and its expired flag.

Verification
REQ-041 Aligned load, addr 0x0000_0010, ready on the first ACCESS cycle with rdata 0xDEAD_BEEF:
- stall is high for 2 cycles;
- the next cycle gives read_data_wb = 0xDEAD_BEEF and reg_write_wb = 1;
- dmem_req is high for exactly 1 cycle.
REQ-042 Store to addr 0x20, data 0x1234_5678, ready delayed 3 cycles:
- dmem_we = 1 and dmem_wdata stay stable for all 3 cycles;
- stall is high for 4 cycles;
- reg_write_wb is 0 throughout.
REQ-043 Load to addr 0x13 -> misalign_err pulses once, dmem_req stays 0, stall stays 0, reg_write_wb = 0.
REQ-044 TIMEOUT_CYCLES = 4, ready held low -> timeout_err pulses after 4 ACCESS cycles, then DONE with reg_write_wb = 0, then IDLE.
REQ-045 Branch with zero_mem = 1 and add_sum_mem = 0x40 -> pc_src = 1 and branch_target = 0x40 in the same cycle; pc_src = 0 if the same condition occurs during a stall.
REQ-046 Reset in the second ACCESS cycle -> the next cycle shows dmem_req = 0, FSM in IDLE and all outputs 0.
